// File: rtl/cursor_position_ctrl.sv
// Cursor-square position controller: debounced-free direction buttons with tap and
// hold-to-repeat, moves applied only at frame start, plus a registered in_square flag.
module cursor_position_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SQ_W       = 8,
  parameter int SQ_H       = 8,
  parameter int STEP       = 4,
  parameter int HOLD_CYC   = 12500000,
  parameter int REPEAT_CYC = 2500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        frame_start,
  input  logic [12:0] row,
  input  logic [12:0] col,
  output logic [15:0] center_row,
  output logic [15:0] center_col,
  output logic [15:0] square_top,
  output logic [15:0] square_bottom,
  output logic [15:0] square_left,
  output logic [15:0] square_right,
  output logic        in_square,
  output logic        move_pending
);

  localparam logic [15:0] HALF_W    = 16'(SQ_W / 2);
  localparam logic [15:0] HALF_H    = 16'(SQ_H / 2);
  localparam logic [15:0] COL_MIN   = 16'(SQ_W / 2);
  localparam logic [15:0] COL_MAX   = 16'(H_ACTIVE - 1 - SQ_W / 2);
  localparam logic [15:0] ROW_MIN   = 16'(SQ_H / 2);
  localparam logic [15:0] ROW_MAX   = 16'(V_ACTIVE - 1 - SQ_H / 2);
  localparam logic [15:0] STEP16    = 16'(STEP);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYC - 1);
  localparam logic [31:0] REP_LAST  = 32'(REPEAT_CYC - 1);

  // Encoding doubles as the bit index into the synced button vector.
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_e;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_e;

  logic [3:0]  btn_raw, btn_s1, btn_s2;
  state_e      state, state_nx;
  dir_e        lat_dir, lat_nx, pick_dir, pending_dir;
  logic [31:0] cnt, cnt_nx;
  logic        req;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  always_comb begin
    pick_dir = DIR_UP;
    if (btn_s2[3])      pick_dir = DIR_RIGHT;
    else if (btn_s2[2]) pick_dir = DIR_LEFT;
    else if (btn_s2[1]) pick_dir = DIR_DOWN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_dir <= DIR_UP;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      lat_dir <= lat_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lat_nx   = lat_dir;
    req      = 1'b0;
    case (state)
      IDLE: if (|btn_s2) begin
        lat_nx   = pick_dir;
        req      = 1'b1;
        cnt_nx   = '0;
        state_nx = DELAY;
      end
      DELAY: begin
        if (!btn_s2[lat_dir]) state_nx = IDLE;
        else if (cnt == HOLD_LAST) begin
          req      = 1'b1;
          cnt_nx   = '0;
          state_nx = REPEAT;
        end else cnt_nx = cnt + 32'd1;
      end
      REPEAT: begin
        if (!btn_s2[lat_dir]) state_nx = IDLE;
        else if (cnt == REP_LAST) begin
          req    = 1'b1;
          cnt_nx = '0;
        end else cnt_nx = cnt + 32'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  function automatic logic [15:0] inc_clamp(input logic [15:0] c, input logic [15:0] mx);
    logic [16:0] s;
    s = {1'b0, c} + {1'b0, STEP16};
    return (s > {1'b0, mx}) ? mx : s[15:0];
  endfunction

  function automatic logic [15:0] dec_clamp(input logic [15:0] c, input logic [15:0] mn);
    return (c < mn + STEP16) ? mn : c - STEP16;
  endfunction

  // Single-entry move buffer; a later request only replaces the direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      move_pending <= 1'b0;
      pending_dir  <= DIR_UP;
      center_row   <= 16'(V_ACTIVE / 2);
      center_col   <= 16'(H_ACTIVE / 2);
    end else begin
      move_pending <= req | (move_pending & ~frame_start);
      if (req) pending_dir <= lat_nx;
      if (frame_start && move_pending) begin
        case (pending_dir)
          DIR_RIGHT: center_col <= inc_clamp(center_col, COL_MAX);
          DIR_LEFT:  center_col <= dec_clamp(center_col, COL_MIN);
          DIR_DOWN:  center_row <= inc_clamp(center_row, ROW_MAX);
          default:   center_row <= dec_clamp(center_row, ROW_MIN);
        endcase
      end
    end
  end

  assign square_top    = center_row - HALF_H;
  assign square_bottom = center_row + HALF_H;
  assign square_left   = center_col - HALF_W;
  assign square_right  = center_col + HALF_W;

  always_ff @(posedge clk) begin
    if (rst) in_square <= 1'b0;
    else in_square <= ({3'b0, row} >= square_top) && ({3'b0, row} <= square_bottom) &&
                      ({3'b0, col} >= square_left) && ({3'b0, col} <= square_right);
  end

endmodule

// File: tb/tb_cursor_position_ctrl.sv
// Scoreboard bench: stimulus queues expected centre moves and probe values; the
// monitor pops a move whenever the centre changes and drains probes each negedge.
module tb_cursor_position_ctrl;

  logic        clk, rst, btn_up, btn_down, btn_left, btn_right, frame_start;
  logic [12:0] row, col;
  logic [15:0] center_row, center_col, square_top, square_bottom, square_left, square_right;
  logic        in_square, move_pending;

  cursor_position_ctrl #(.HOLD_CYC(10), .REPEAT_CYC(4)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .frame_start(frame_start), .row(row), .col(col),
    .center_row(center_row), .center_col(center_col), .square_top(square_top),
    .square_bottom(square_bottom), .square_left(square_left), .square_right(square_right),
    .in_square(in_square), .move_pending(move_pending)
  );

  localparam int P_ROW = 0, P_COL = 1, P_TOP = 2, P_BOT = 3, P_LEFT = 4, P_RIGHT = 5,
                 P_INSQ = 6, P_PEND = 7;

  typedef struct { string name; int sel; int exp; } probe_t;
  typedef struct { int r; int c; } mv_t;

  probe_t      pq[$];
  mv_t         mq[$];
  int          checks = 0, errors = 0;
  logic [31:0] prev = 32'hFFFF_FFFF;
  logic        done = 1'b0, mon_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int get(input int sel);
    case (sel)
      P_ROW:   return int'(center_row);
      P_COL:   return int'(center_col);
      P_TOP:   return int'(square_top);
      P_BOT:   return int'(square_bottom);
      P_LEFT:  return int'(square_left);
      P_RIGHT: return int'(square_right);
      P_INSQ:  return int'(in_square);
      P_PEND:  return int'(move_pending);
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    probe_t p;
    mv_t    m;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      chk(p.name, get(p.sel), p.exp);
    end
    if ({center_row, center_col} != prev) begin
      if (mq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_move: got row %0d col %0d, expected no change",
                 center_row, center_col);
      end else begin
        m = mq.pop_front();
        chk("move_row", int'(center_row), m.r);
        chk("move_col", int'(center_col), m.c);
        chk("move_top", int'(square_top), m.r - 4);
        chk("move_bottom", int'(square_bottom), m.r + 4);
        chk("move_left", int'(square_left), m.c - 4);
        chk("move_right", int'(square_right), m.c + 4);
      end
    end
    prev = {center_row, center_col};
    if (done && !mon_done) begin
      chk("moves_outstanding", mq.size(), 0);
      mon_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string name, input int sel, input int exp);
    pq.push_back('{name, sel, exp});
  endtask

  task automatic push_mv(input int r, input int c);
    mq.push_back('{r, c});
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_right, btn_left, btn_down, btn_up} = b;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic tap(input logic [3:0] b);
    set_btn(b);
    repeat (3) step();
    set_btn(4'b0000);
    repeat (5) step();
  endtask

  // Hold with frame_start every cycle so each request lands as its own move.
  task automatic hold(input logic [3:0] b, input int n);
    frame_start = 1'b1;
    set_btn(b);
    repeat (n) step();
    set_btn(4'b0000);
    repeat (6) step();
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; row = '0; col = '0;
    set_btn(4'b0000);
    push_mv(240, 320);
    repeat (3) step();
    rst = 1'b0;
    probe("rst_row", P_ROW, 240);   probe("rst_col", P_COL, 320);
    probe("rst_top", P_TOP, 236);   probe("rst_bottom", P_BOT, 244);
    probe("rst_left", P_LEFT, 316); probe("rst_right", P_RIGHT, 324);
    probe("rst_insq", P_INSQ, 0);   probe("rst_pend", P_PEND, 0);

    // Taps: one move per frame_start, no accumulation.
    tap(4'b1000);
    probe("tap_pend", P_PEND, 1);
    push_mv(240, 324);
    fs();
    probe("fs_pend_clr", P_PEND, 0); probe("tap_left", P_LEFT, 320); probe("tap_right", P_RIGHT, 328);
    fs();
    probe("fs_no_move", P_COL, 324);
    tap(4'b1000);
    tap(4'b1000);
    push_mv(240, 328);
    fs();
    fs();
    probe("two_taps_one_move", P_COL, 328);

    // Hold up: requests at relative edges 2,12,16,20,24,28.
    for (int k = 1; k <= 6; k++) push_mv(240 - 4 * k, 328);
    frame_start = 1'b1;
    btn_up = 1'b1;
    for (int j = 0; j < 34; j++) begin
      if (j == 29) btn_up = 1'b0;
      step();
      probe("hold_pend", P_PEND,
            (j == 2 || j == 12 || j == 16 || j == 20 || j == 24 || j == 28) ? 1 : 0);
    end
    frame_start = 1'b0;
    probe("hold_row", P_ROW, 216);

    // Clamping on all four edges.
    for (int c = 332; c <= 632; c += 4) push_mv(216, c);
    push_mv(216, 635);
    hold(4'b1000, 380);
    probe("clamp_col_max", P_COL, 635); probe("clamp_sq_right", P_RIGHT, 639);
    for (int c = 631; c >= 7; c -= 4) push_mv(216, c);
    push_mv(216, 4);
    hold(4'b0100, 700);
    probe("clamp_col_min", P_COL, 4); probe("clamp_sq_left", P_LEFT, 0);
    for (int r = 212; r >= 4; r -= 4) push_mv(r, 4);
    hold(4'b0001, 260);
    probe("clamp_row_min", P_ROW, 4); probe("clamp_sq_top", P_TOP, 0);

    // Priority and request coincident with an applying frame_start.
    push_mv(4, 8);
    tap(4'b1100);
    fs();
    probe("prio_right", P_COL, 8);
    tap(4'b0010);
    probe("down_pend", P_PEND, 1);
    btn_right = 1'b1;
    step();
    step();
    frame_start = 1'b1;
    push_mv(8, 8);
    step();
    frame_start = 1'b0;
    probe("coincident_pend", P_PEND, 1);
    btn_right = 1'b0;
    repeat (5) step();
    push_mv(8, 12);
    fs();
    probe("coincident_applied_pend", P_PEND, 0);

    // Reset while in REPEAT with the button still held.
    btn_down = 1'b1;
    repeat (16) step();
    probe("repeat_pend", P_PEND, 1);
    push_mv(240, 320);
    rst = 1'b1;
    step();
    probe("rst_mid_pend", P_PEND, 0);
    step();
    rst = 1'b0;
    step();
    probe("post_rst_e1", P_PEND, 0);
    step();
    probe("post_rst_e2", P_PEND, 0);
    step();
    probe("post_rst_req", P_PEND, 1);
    btn_down = 1'b0;
    repeat (5) step();

    // in_square: registered, inclusive bounds.
    row = 13'd236; col = 13'd316;
    probe("insq_before_edge", P_INSQ, 0);
    step();
    probe("insq_corner_tl", P_INSQ, 1);
    row = 13'd245;
    step();
    probe("insq_row_below", P_INSQ, 0);
    row = 13'd244; col = 13'd324;
    step();
    probe("insq_corner_br", P_INSQ, 1);
    col = 13'd325;
    step();
    probe("insq_col_right", P_INSQ, 0);
    row = 13'd235; col = 13'd320;
    step();
    probe("insq_row_above", P_INSQ, 0);
    push_mv(244, 320);
    fs();
    probe("final_pend", P_PEND, 0);

    done = 1'b1;
    repeat (3) step();
    if (!mon_done) begin
      $display("FAIL monitor_done: got 0, expected 1");
      errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
